// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - instruction ROM bus master holding the PC and feeding decode
// Runs FETCH -> CAPTURE -> VALID per word and halts on ebreak or a misaligned PC.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter bit          HALT_ON_EBREAK = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] bus_addr,
  output logic        bus_rw,
  output logic [1:0]  bus_size,
  input  logic [31:0] bus_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        halted,
  output logic        fault
);

  localparam logic [31:0] EBREAK_WORD = 32'h0010_0073;
  localparam logic [31:0] NOP_WORD    = 32'h0000_0013;
  localparam logic [1:0]  SIZE_WORD   = 2'b11;
  localparam logic [1:0]  SIZE_IDLE   = 2'b00;

  typedef enum logic [2:0] {
    S_FETCH,
    S_CAPTURE,
    S_VALID,
    S_HALTED,
    S_FAULT
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic [31:0] r_inst_pc;
  logic        r_inst_valid;
  logic        r_halted;
  logic        r_fault;

  state_t      w_next_state;
  logic [31:0] w_next_pc;
  logic [31:0] w_next_inst;
  logic [31:0] w_next_inst_pc;
  logic        w_next_inst_valid;
  logic        w_next_halted;
  logic        w_next_fault;
  logic        w_misaligned;
  logic        w_transfer;
  logic        w_is_ebreak;
  logic        w_bus_active;

  assign w_misaligned = (r_pc[1:0] != 2'b00);
  // A redirect voids any handshake that happens in the same cycle.
  assign w_transfer   = r_inst_valid & inst_ready & ~redirect_valid;
  assign w_is_ebreak  = (r_inst == EBREAK_WORD) && HALT_ON_EBREAK;

  always_comb begin
    w_next_state      = r_state;
    w_next_pc         = r_pc;
    w_next_inst       = r_inst;
    w_next_inst_pc    = r_inst_pc;
    w_next_inst_valid = r_inst_valid;
    w_next_halted     = r_halted;
    w_next_fault      = r_fault;

    case (r_state)
      S_FETCH: begin
        if (redirect_valid) begin
          w_next_pc    = redirect_pc;
          w_next_state = S_FETCH;
        end else if (w_misaligned) begin
          w_next_fault = 1'b1;
          w_next_state = S_FAULT;
        end else begin
          w_next_state = S_CAPTURE;
        end
      end

      S_CAPTURE: begin
        if (redirect_valid) begin
          w_next_pc    = redirect_pc;
          w_next_state = S_FETCH;
        end else begin
          w_next_inst       = bus_data;
          w_next_inst_pc    = r_pc;
          w_next_pc         = r_pc + 32'd4;
          w_next_inst_valid = 1'b1;
          w_next_state      = S_VALID;
        end
      end

      S_VALID: begin
        if (redirect_valid) begin
          w_next_pc         = redirect_pc;
          w_next_inst_valid = 1'b0;
          w_next_state      = S_FETCH;
        end else if (w_transfer) begin
          w_next_inst_valid = 1'b0;
          if (w_is_ebreak) begin
            w_next_halted = 1'b1;
            w_next_state  = S_HALTED;
          end else begin
            w_next_state = S_FETCH;
          end
        end
      end

      S_HALTED: begin
        w_next_inst_valid = 1'b0;
        w_next_state      = S_HALTED;
      end

      S_FAULT: begin
        w_next_inst_valid = 1'b0;
        w_next_state      = S_FAULT;
      end

      default: begin
        w_next_inst_valid = 1'b0;
        w_next_state      = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_FETCH;
      r_pc         <= RESET_PC;
      r_inst       <= NOP_WORD;
      r_inst_pc    <= 32'h0000_0000;
      r_inst_valid <= 1'b0;
      r_halted     <= 1'b0;
      r_fault      <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_pc         <= w_next_pc;
      r_inst       <= w_next_inst;
      r_inst_pc    <= w_next_inst_pc;
      r_inst_valid <= w_next_inst_valid;
      r_halted     <= w_next_halted;
      r_fault      <= w_next_fault;
    end
  end

  // Reset gates the bus so no slave sees a read while rst_n is held low.
  assign w_bus_active = rst_n &&
                        (((r_state == S_FETCH) && !w_misaligned) || (r_state == S_CAPTURE));

  assign bus_addr   = r_pc;
  assign bus_rw     = 1'b0;
  assign bus_size   = w_bus_active ? SIZE_WORD : SIZE_IDLE;
  assign inst_valid = r_inst_valid;
  assign inst       = r_inst;
  assign inst_pc    = r_inst_pc;
  assign halted     = r_halted;
  assign fault      = r_fault;

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - directed self-checking bench for instruction_fetch
// A registered ROM model answers word reads one cycle after the capture edge.
module tb_instruction_fetch;

  logic        clk;
  logic        rst_n;
  logic [31:0] bus_addr;
  logic        bus_rw;
  logic [1:0]  bus_size;
  logic [31:0] bus_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halted;
  logic        fault;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] rom [0:15];
  logic [31:0] rom_q;

  instruction_fetch #(
    .RESET_PC       (32'h0000_0000),
    .HALT_ON_EBREAK (1'b1)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus_addr       (bus_addr),
    .bus_rw         (bus_rw),
    .bus_size       (bus_size),
    .bus_data       (bus_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halted         (halted),
    .fault          (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 32'h0000_0013 + (i << 20);
    rom[0]  = 32'h8000_00b7;
    rom[1]  = 32'h0000_0113;
    rom[2]  = 32'h3ff0_0193;
    rom[3]  = 32'h0011_0113;
    rom[15] = 32'h0010_0073;
  end

  always @(posedge clk) begin
    if (bus_size == 2'b11 && !bus_rw)
      rom_q <= (bus_addr < 32'd64) ? rom[bus_addr[5:2]] : 32'h0000_0013;
  end
  assign bus_data = rom_q;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    inst_ready     = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    step();
    step();
    chk("rst_valid",   inst_valid, 0);
    chk("rst_inst",    inst, 32'h0000_0013);
    chk("rst_inst_pc", inst_pc, 0);
    chk("rst_halted",  halted, 0);
    chk("rst_fault",   fault, 0);
    chk("rst_size",    bus_size, 0);
    chk("rst_rw",      bus_rw, 0);

    // Sequential fetch at ready=1
    rst_n = 1'b1;
    #1;
    chk("f0_size", bus_size, 2'b11);
    chk("f0_addr", bus_addr, 0);
    step();
    chk("c0_size",  bus_size, 2'b11);
    chk("c0_valid", inst_valid, 0);
    step();
    chk("v0_valid", inst_valid, 1);
    chk("v0_inst",  inst, 32'h8000_00b7);
    chk("v0_pc",    inst_pc, 0);
    chk("v0_size",  bus_size, 0);
    step();
    chk("f1_valid", inst_valid, 0);
    chk("f1_addr",  bus_addr, 32'h4);
    chk("f1_size",  bus_size, 2'b11);
    step();
    step();
    chk("v1_valid", inst_valid, 1);
    chk("v1_inst",  inst, 32'h0000_0113);
    chk("v1_pc",    inst_pc, 32'h4);

    // Stall with ready low
    inst_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_valid", inst_valid, 1);
      chk("stall_inst",  inst, 32'h0000_0113);
      chk("stall_pc",    inst_pc, 32'h4);
      chk("stall_size",  bus_size, 0);
    end
    inst_ready = 1'b1;
    step();
    chk("post_stall_addr",  bus_addr, 32'h8);
    chk("post_stall_valid", inst_valid, 0);
    step();
    step();
    chk("v2_inst", inst, 32'h3ff0_0193);
    chk("v2_pc",   inst_pc, 32'h8);
    step();
    chk("f3_addr", bus_addr, 32'hc);

    // Redirect during CAPTURE of pc 0x04
    redirect_valid = 1'b1;
    redirect_pc    = 32'h4;
    step();
    redirect_valid = 1'b0;
    chk("rd_f_addr", bus_addr, 32'h4);
    step();
    chk("rd_c_size", bus_size, 2'b11);
    chk("rd_c_addr", bus_addr, 32'h4);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hc;
    step();
    redirect_valid = 1'b0;
    chk("rd_valid", inst_valid, 0);
    chk("rd_addr",  bus_addr, 32'hc);
    chk("rd_size",  bus_size, 2'b11);
    step();
    step();
    chk("rd_v_valid", inst_valid, 1);
    chk("rd_v_inst",  inst, 32'h0011_0113);
    chk("rd_v_pc",    inst_pc, 32'hc);

    // Redirect coinciding with a valid&ready is not a transfer
    redirect_valid = 1'b1;
    redirect_pc    = 32'h3c;
    step();
    redirect_valid = 1'b0;
    chk("void_valid", inst_valid, 0);
    chk("void_addr",  bus_addr, 32'h3c);
    step();
    step();
    chk("eb_valid", inst_valid, 1);
    chk("eb_inst",  inst, 32'h0010_0073);
    chk("eb_pc",    inst_pc, 32'h3c);

    // Redirect on the ebreak transfer cycle cancels the halt
    redirect_valid = 1'b1;
    redirect_pc    = 32'h3c;
    step();
    redirect_valid = 1'b0;
    chk("eb_cancel_halted", halted, 0);
    chk("eb_cancel_size",   bus_size, 2'b11);
    chk("eb_cancel_addr",   bus_addr, 32'h3c);
    step();
    step();
    chk("eb2_inst", inst, 32'h0010_0073);
    step();
    chk("halt_halted", halted, 1);
    chk("halt_valid",  inst_valid, 0);
    chk("halt_size",   bus_size, 0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0;
    step();
    step();
    redirect_valid = 1'b0;
    chk("halt_hold",       halted, 1);
    chk("halt_hold_size",  bus_size, 0);
    chk("halt_hold_valid", inst_valid, 0);

    // Reset clears the halt
    rst_n = 1'b0;
    #1;
    chk("rst2_halted", halted, 0);
    chk("rst2_inst",   inst, 32'h0000_0013);
    step();
    rst_n = 1'b1;
    #1;
    chk("rst2_addr", bus_addr, 0);
    chk("rst2_size", bus_size, 2'b11);

    // Misaligned redirect
    redirect_valid = 1'b1;
    redirect_pc    = 32'h6;
    step();
    redirect_valid = 1'b0;
    chk("mis_size",  bus_size, 0);
    chk("mis_fault", fault, 0);
    chk("mis_addr",  bus_addr, 32'h6);
    step();
    chk("fault_set",   fault, 1);
    chk("fault_size",  bus_size, 0);
    chk("fault_valid", inst_valid, 0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0;
    step();
    step();
    redirect_valid = 1'b0;
    chk("fault_hold",      fault, 1);
    chk("fault_hold_size", bus_size, 0);

    // Reset asserted mid-CAPTURE
    rst_n = 1'b0;
    step();
    chk("rst3_fault", fault, 0);
    rst_n = 1'b1;
    step();
    step();
    chk("rst3_v_inst", inst, 32'h8000_00b7);
    step();
    step();
    chk("rst3_c_addr", bus_addr, 32'h4);
    chk("rst3_c_size", bus_size, 2'b11);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_size",    bus_size, 0);
    chk("async_valid",   inst_valid, 0);
    chk("async_inst",    inst, 32'h0000_0013);
    chk("async_inst_pc", inst_pc, 0);
    chk("async_addr",    bus_addr, 0);
    step();
    rst_n = 1'b1;
    #1;
    chk("restart_addr", bus_addr, 0);
    chk("restart_size", bus_size, 2'b11);
    step();
    step();
    chk("restart_valid", inst_valid, 1);
    chk("restart_inst",  inst, 32'h8000_00b7);
    chk("restart_pc",    inst_pc, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
